fetch_sequencer: RTL and testbench

- Controls the program counter register and the instruction-memory fetch port.
- Drives the PC register input each cycle: hold, sequential step, branch/jump redirect, or trap vector.
- Issues one outstanding request at a time on a req/gnt/rvalid imem port and holds the fetched instruction until decode accepts it.
- Sits between the PC register, instruction memory, the execute-stage redirect logic and decode.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// The state encoding is kept fixed so it matches the existing waveform decoders.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned PC_STEP_DEFAULT  = 4;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0080;

  // Instructions are word aligned, so the low two bits of any redirect target are cleared.
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Drives the next PC to the external PC register and runs a single-outstanding
// req/gnt/rvalid fetch. The fetched word is held in a one-entry buffer until decode takes it.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready
);

  fetch_state_e    state_q, state_d;
  logic            kill_q, kill_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;

  logic            flush;
  logic            outstanding;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] flush_target;

  // A trap overrides a simultaneous branch/jump redirect.
  assign flush        = trap_valid | redirect_valid;
  assign raw_target   = trap_valid ? TRAP_VEC : redirect_target;
  assign flush_target = {raw_target[XLEN-1:2], raw_target[1:0] & ALIGN_MASK[1:0]};

  // A response is still owed by memory if we are waiting without data this cycle,
  // or if the request is being granted right now.
  assign outstanding = ((state_q == WAIT) && !imem_rvalid) ||
                       ((state_q == REQ)  && imem_gnt);

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_cur;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

  // NOTE: every output of this block gets a default before any branch, so no path can leave a latch.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    pc_next    = pc_cur;

    if (flush) begin
      pc_next    = flush_target;
      if_valid_d = 1'b0;
      if (outstanding) begin
        kill_d  = 1'b1;
        state_d = WAIT;
      end else begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!if_valid_q || if_ready) state_d = REQ;
        end
        REQ: begin
          if (imem_gnt) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              // Stale response from before a redirect: drop it and refetch at the new PC.
              kill_d  = 1'b0;
              state_d = IDLE;
            end else begin
              if_instr_d = imem_rdata;
              if_pc_d    = pc_cur;
              pc_next    = pc_cur + XLEN'(PC_STEP);
              if_valid_d = 1'b1;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (if_ready) begin
            if_valid_d = 1'b0;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an external PC register, a transaction-level
// reference model checked every cycle, and literal expectations at key points.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  int n_total = 0;
  int n_pass  = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .pc_cur         (pc_cur),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid     (trap_valid),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register, reset to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_cur <= 32'h0;
    else       pc_cur <= pc_next;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks the fetch as transactions (buffer, owed response,
  // whether that response is stale, and a one-cycle bubble before a fresh request).
  logic        m_buf_v, m_out, m_killed, m_bubble;
  logic [31:0] m_buf_instr, m_buf_pc;

  always @(posedge clk or posedge reset) begin : model
    logic        bv, out, kil, bub, req_now;
    logic [31:0] ins, bpc;
    if (reset) begin
      m_buf_v     <= 1'b0;
      m_out       <= 1'b0;
      m_killed    <= 1'b0;
      m_bubble    <= 1'b1;
      m_buf_instr <= 32'h0;
      m_buf_pc    <= 32'h0;
    end else begin
      bv  = m_buf_v;
      out = m_out;
      kil = m_killed;
      bub = 1'b0;
      ins = m_buf_instr;
      bpc = m_buf_pc;
      req_now = !m_bubble && !m_out && !m_buf_v;
      if (trap_valid || redirect_valid) begin
        bv = 1'b0;
        if ((m_out && !imem_rvalid) || (req_now && imem_gnt)) begin
          out = 1'b1;
          kil = 1'b1;
        end else begin
          out = 1'b0;
          kil = 1'b0;
          bub = 1'b1;
        end
      end else if (m_out && imem_rvalid) begin
        out = 1'b0;
        if (m_killed) begin
          kil = 1'b0;
          bub = 1'b1;
        end else begin
          bv  = 1'b1;
          ins = imem_rdata;
          bpc = pc_cur;
        end
      end else if (req_now && imem_gnt) begin
        out = 1'b1;
      end else if (m_buf_v && if_ready) begin
        bv = 1'b0;
      end
      m_buf_v     <= bv;
      m_out       <= out;
      m_killed    <= kil;
      m_bubble    <= bub;
      m_buf_instr <= ins;
      m_buf_pc    <= bpc;
    end
  end

  always @(negedge clk) begin : compare
    logic        exp_req;
    logic [31:0] tgt, exp_pc;
    #2;
    if (!reset) begin
      exp_req = !m_bubble && !m_out && !m_buf_v;
      tgt     = trap_valid ? 32'h0000_0080 : redirect_target;
      if (trap_valid || redirect_valid)          exp_pc = tgt & 32'hFFFF_FFFC;
      else if (m_out && imem_rvalid && !m_killed) exp_pc = pc_cur + 32'd4;
      else                                        exp_pc = pc_cur;
      check("cyc_req", {31'd0, imem_req}, {31'd0, exp_req});
      check("cyc_addr", imem_addr, pc_cur);
      check("cyc_pc_next", pc_next, exp_pc);
      check("cyc_if_valid", {31'd0, if_valid}, {31'd0, m_buf_v});
      if (m_buf_v) begin
        check("cyc_if_instr", if_instr, m_buf_instr);
        check("cyc_if_pc", if_pc, m_buf_pc);
      end
    end
  end

  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdir, input logic [31:0] tgt, input logic trp,
                      input logic rdy);
    @(negedge clk);
    imem_gnt        = g;
    imem_rvalid     = rv;
    imem_rdata      = rd;
    redirect_valid  = rdir;
    redirect_target = tgt;
    trap_valid      = trp;
    if_ready        = rdy;
  endtask

  initial begin
    reset           = 1'b1;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'h0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap_valid      = 1'b0;
    if_ready        = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_pc_next", pc_next, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    #3 check("idle_req", {31'd0, imem_req}, 32'd0);

    // First fetch with immediate grant and one-cycle response.
    step(1, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("f1_req", {31'd0, imem_req}, 32'd1);
    check("f1_addr", imem_addr, 32'h0);
    step(0, 1, 32'h0050_0093, 0, 32'h0, 0, 1);
    #3 check("f1_pc_next", pc_next, 32'h4);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("f1_if_valid", {31'd0, if_valid}, 32'd1);
    check("f1_if_pc", if_pc, 32'h0);
    check("f1_if_instr", if_instr, 32'h0050_0093);

    // Second request waits one cycle for grant and one for data.
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("f2_addr", imem_addr, 32'h4);
    check("f2_req", {31'd0, imem_req}, 32'd1);
    step(1, 0, 32'h0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    step(0, 1, 32'h1111_1111, 0, 32'h0, 0, 0);

    // Decode stalls for five cycles with the buffer full.
    repeat (5) begin
      step(0, 0, 32'h0, 0, 32'h0, 0, 0);
      #3 check("stall_if_valid", {31'd0, if_valid}, 32'd1);
      check("stall_if_instr", if_instr, 32'h1111_1111);
      check("stall_if_pc", if_pc, 32'h4);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_pc_next", pc_next, 32'h8);
    end
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);

    // Redirect while waiting: the late response is killed.
    step(1, 0, 32'h0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 1, 32'h200, 0, 1);
    #3 check("kill_pc_next", pc_next, 32'h200);
    step(0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 1);
    #3 check("kill_pc_hold", pc_next, 32'h200);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("kill_if_valid", {31'd0, if_valid}, 32'd0);
    check("kill_req", {31'd0, imem_req}, 32'd0);
    step(1, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("kill_next_addr", imem_addr, 32'h200);
    step(0, 1, 32'h2222_2222, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("kill_refetch_pc", if_pc, 32'h200);

    // Trap and redirect together while requesting without grant: trap wins.
    step(0, 0, 32'h0, 1, 32'h40, 1, 1);
    #3 check("trap_pc_next", pc_next, 32'h80);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("trap_bubble_req", {31'd0, imem_req}, 32'd0);
    step(1, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("trap_addr", imem_addr, 32'h80);
    step(0, 1, 32'h3333_3333, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);

    // Misaligned redirect coinciding with a grant.
    step(1, 0, 32'h0, 1, 32'h103, 0, 1);
    #3 check("align_pc_next", pc_next, 32'h100);
    step(0, 1, 32'hBADB_AD00, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);

    // Move to the top of the address space and fetch across the wrap.
    step(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 1);
    #3 check("align_addr", imem_addr, 32'h100);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    step(1, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 1, 32'h4444_4444, 0, 32'h0, 0, 0);
    #3 check("wrap_pc_next", pc_next, 32'h0);

    // Redirect while holding with if_ready high discards the held word.
    step(0, 0, 32'h0, 1, 32'h300, 0, 1);
    #3 check("hold_if_pc", if_pc, 32'hFFFF_FFFC);
    check("hold_pc_next", pc_next, 32'h300);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("hold_drop_valid", {31'd0, if_valid}, 32'd0);
    check("hold_drop_req", {31'd0, imem_req}, 32'd0);
    step(1, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("hold_next_addr", imem_addr, 32'h300);

    // Redirect in the same cycle as a live response: data dropped, no kill.
    step(0, 1, 32'h5555_5555, 1, 32'h400, 0, 1);
    #3 check("race_pc_next", pc_next, 32'h400);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("race_if_valid", {31'd0, if_valid}, 32'd0);
    check("race_req", {31'd0, imem_req}, 32'd0);
    step(1, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("race_addr", imem_addr, 32'h400);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);

    // Asynchronous reset while a response is owed.
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_if_instr", if_instr, 32'h0);
    check("mid_rst_if_pc", if_pc, 32'h0);
    check("mid_rst_pc_next", pc_next, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #3 check("post_rst_idle", {31'd0, imem_req}, 32'd0);
    step(1, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    step(0, 1, 32'h0A0A_0A0A, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    #3 check("post_rst_instr", if_instr, 32'h0A0A_0A0A);
    check("post_rst_if_pc", if_pc, 32'h0);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
